// File: rtl/fir_tap_sequencer.sv
// Front-end sequencer for the 4-lane direct-form FIR: sample strobe, 4*TAPS delay line, MAC lane stepping.
// Optional FIR_ZERO_FLUSH_EN: dropping iEnable also clears the delay line and fill counter.
module fir_tap_sequencer #(
  parameter int DIV  = 20,
  parameter int TAPS = 10,
  parameter int DW   = 16
) (
  input  logic                 iClk_12M,
  input  logic                 iRst,
  input  logic                 iEnable,
  input  logic signed [DW-1:0] iFirIn,
  output logic                 oEnSample_600k,
  output logic                 oMacClr,
  output logic                 oMacEn,
  output logic [3:0]           oTapIdx,
  output logic signed [DW-1:0] oTap1,
  output logic signed [DW-1:0] oTap2,
  output logic signed [DW-1:0] oTap3,
  output logic signed [DW-1:0] oTap4,
  output logic                 oEnDelay
);

  localparam int NENT = 4 * TAPS;
  localparam int FW   = $clog2(NENT + 1);
  localparam int AW   = $clog2(NENT);
  localparam int CW   = $clog2(DIV);

  localparam logic [3:0]    LAST_TAP  = 4'(TAPS - 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(DIV - TAPS - 3);
  localparam logic [FW-1:0] FULL      = FW'(NENT);

  typedef enum logic [2:0] {IDLE, STROBE, CLEAR, ACCUM, WAIT} state_t;

  state_t               state;
  logic [CW-1:0]        waitCnt;
  logic [FW-1:0]        fill;
  logic signed [DW-1:0] dly [NENT];
  logic [3:0]           nextIdx;
  logic                 tapLoad;

  function automatic logic [AW-1:0] tapAddr(input int lane, input logic [3:0] idx);
    return AW'(lane * TAPS) + AW'(idx);
  endfunction

  // Tap registers are loaded one cycle ahead so they line up with oMacEn/oTapIdx.
  assign nextIdx = (state == CLEAR) ? 4'd0 : oTapIdx + 4'd1;
  assign tapLoad = iEnable && ((state == CLEAR) || ((state == ACCUM) && (oTapIdx != LAST_TAP)));

  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      state          <= IDLE;
      waitCnt        <= '0;
      oEnSample_600k <= 1'b0;
      oMacClr        <= 1'b0;
      oMacEn         <= 1'b0;
      oTapIdx        <= '0;
      oEnDelay       <= 1'b0;
    end else if (!iEnable) begin
      // An aborted accumulation must never be reported as valid.
      state          <= IDLE;
      waitCnt        <= '0;
      oEnSample_600k <= 1'b0;
      oMacClr        <= 1'b0;
      oMacEn         <= 1'b0;
      oTapIdx        <= '0;
      oEnDelay       <= 1'b0;
    end else begin
      oEnSample_600k <= 1'b0;
      oMacClr        <= 1'b0;
      case (state)
        IDLE: begin
          state          <= STROBE;
          oEnSample_600k <= 1'b1;
        end
        STROBE: begin
          state   <= CLEAR;
          oMacClr <= 1'b1;
        end
        CLEAR: begin
          state   <= ACCUM;
          oMacEn  <= 1'b1;
          oTapIdx <= '0;
        end
        ACCUM: begin
          if (oTapIdx == LAST_TAP) begin
            state   <= WAIT;
            oMacEn  <= 1'b0;
            oTapIdx <= '0;
            waitCnt <= '0;
            if (fill == FULL) oEnDelay <= 1'b1;
          end else begin
            oTapIdx <= oTapIdx + 4'd1;
          end
        end
        WAIT: begin
          if (waitCnt == LAST_WAIT) begin
            state          <= STROBE;
            oEnSample_600k <= 1'b1;
          end else begin
            waitCnt <= waitCnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Delay line shifts once per period, at the end of the strobe cycle.
  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      for (int k = 0; k < NENT; k++) dly[k] <= '0;
      fill <= '0;
    end else if (!iEnable) begin
`ifdef FIR_ZERO_FLUSH_EN
      for (int k = 0; k < NENT; k++) dly[k] <= '0;
      fill <= '0;
`endif
    end else if (state == STROBE) begin
      dly[0] <= iFirIn;
      for (int k = 1; k < NENT; k++) dly[k] <= dly[k-1];
      if (fill != FULL) fill <= fill + FW'(1);
    end
  end

  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      oTap1 <= '0;
      oTap2 <= '0;
      oTap3 <= '0;
      oTap4 <= '0;
    end else if (tapLoad) begin
      oTap1 <= dly[tapAddr(0, nextIdx)];
      oTap2 <= dly[tapAddr(1, nextIdx)];
      oTap3 <= dly[tapAddr(2, nextIdx)];
      oTap4 <= dly[tapAddr(3, nextIdx)];
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Scoreboard bench for fir_tap_sequencer: stimulus pushes per-period expected tap tables, a monitor checks them.
`timescale 1ns/1ps
module tb_fir_tap_sequencer;

  localparam int DIV  = 20;
  localparam int TAPS = 10;
  localparam int DW   = 16;
  localparam int NENT = 4 * TAPS;

  logic                 iClk_12M;
  logic                 iRst;
  logic                 iEnable;
  logic signed [DW-1:0] iFirIn;
  logic                 oEnSample_600k;
  logic                 oMacClr;
  logic                 oMacEn;
  logic [3:0]           oTapIdx;
  logic signed [DW-1:0] oTap1, oTap2, oTap3, oTap4;
  logic                 oEnDelay;

  fir_tap_sequencer #(.DIV(DIV), .TAPS(TAPS), .DW(DW)) dut (
    .iClk_12M       (iClk_12M),
    .iRst           (iRst),
    .iEnable        (iEnable),
    .iFirIn         (iFirIn),
    .oEnSample_600k (oEnSample_600k),
    .oMacClr        (oMacClr),
    .oMacEn         (oMacEn),
    .oTapIdx        (oTapIdx),
    .oTap1          (oTap1),
    .oTap2          (oTap2),
    .oTap3          (oTap3),
    .oTap4          (oTap4),
    .oEnDelay       (oEnDelay)
  );

  initial iClk_12M = 1'b0;
  always #42 iClk_12M = ~iClk_12M;

  typedef struct packed {
    logic [NENT-1:0][DW-1:0] taps;
    logic                    endly;
  } exp_t;

  exp_t                 q[$];
  logic signed [DW-1:0] mdl [NENT];
  int                   fill;
  int                   tests  = 0;
  int                   errors = 0;
  bit                   monEn  = 0;
  int                   off    = -1;
  bit                   haveCur = 0;
  exp_t                 cur;

  task automatic check(input string nm, input int act, input int expv);
    tests++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic clearModel();
    for (int k = 0; k < NENT; k++) mdl[k] = '0;
    fill = 0;
  endtask

  task automatic shiftModel(input logic [DW-1:0] s);
    for (int k = NENT - 1; k > 0; k--) mdl[k] = mdl[k-1];
    mdl[0] = s;
    if (fill < NENT) fill++;
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_strobe"}, oEnSample_600k, 0);
    check({tag, "_macclr"}, oMacClr, 0);
    check({tag, "_macen"}, oMacEn, 0);
    check({tag, "_tapidx"}, oTapIdx, 0);
    check({tag, "_tap1"}, int'(oTap1), 0);
    check({tag, "_tap2"}, int'(oTap2), 0);
    check({tag, "_tap3"}, int'(oTap3), 0);
    check({tag, "_tap4"}, int'(oTap4), 0);
    check({tag, "_endelay"}, oEnDelay, 0);
  endtask

  // Called at posedge+1 of the cycle before the strobe; returns at the same phase DIV cycles later.
  task automatic period(input logic [DW-1:0] s);
    exp_t e;
    iFirIn = s;
    shiftModel(s);
    for (int k = 0; k < NENT; k++) e.taps[k] = mdl[k];
    e.endly = (fill == NENT);
    q.push_back(e);
    @(posedge iClk_12M); #1;
    check("strobe_on_time", oEnSample_600k, 1);
    repeat (DIV - 1) @(posedge iClk_12M);
    #1;
  endtask

  always @(negedge iClk_12M) begin
    if (!monEn) begin
      off     = -1;
      haveCur = 0;
    end else begin
      if (oEnSample_600k) begin
        if (off >= 0) check("strobe_interval", off + 1, DIV);
        off = 0;
        if (q.size() == 0) begin
          check("scoreboard_underflow", 0, 1);
          haveCur = 0;
        end else begin
          cur     = q.pop_front();
          haveCur = 1;
        end
      end else if (off >= 0) begin
        off++;
        if (off >= DIV) begin
          check("strobe_missing", off, DIV - 1);
          off = -1;
        end
      end
      if (off >= 0) begin
        check("macclr", oMacClr, int'(off == 1));
        if (off >= 2 && off <= TAPS + 1) begin
          check("macen", oMacEn, 1);
          check("tapidx", oTapIdx, off - 2);
          if (haveCur) begin
            check("tap1", int'(oTap1), int'($signed(cur.taps[0*TAPS + off - 2])));
            check("tap2", int'(oTap2), int'($signed(cur.taps[1*TAPS + off - 2])));
            check("tap3", int'(oTap3), int'($signed(cur.taps[2*TAPS + off - 2])));
            check("tap4", int'(oTap4), int'($signed(cur.taps[3*TAPS + off - 2])));
          end
        end else begin
          check("macen_idle", oMacEn, 0);
          check("tapidx_idle", oTapIdx, 0);
        end
        if (off == TAPS + 2 && haveCur) check("endelay", oEnDelay, int'(cur.endly));
      end
    end
  end

  initial begin
    iRst    = 1'b1;
    iEnable = 1'b0;
    iFirIn  = '0;
    clearModel();
    repeat (3) @(posedge iClk_12M);
    #1;
    checkAllZero("reset");

    iRst = 1'b0;
    repeat (5) @(posedge iClk_12M);
    #1;
    check("idle_no_strobe", oEnSample_600k, 0);

    // Impulse, then zeros past full fill, then sign-edge samples.
    iEnable = 1'b1;
    monEn   = 1;
    period(16'h0100);
    for (int p = 2; p <= 41; p++) period(16'h0000);
    period(16'hFFFF);
    period(16'h8000);
    period(16'h7FFF);
    period(16'h1234);
    period(16'hFEDC);

    // Abort mid-ACCUM: strobe still captured, then disable at S+5 for 30 cycles.
    iFirIn = 16'h5555;
    monEn  = 0;
    shiftModel(16'h5555);
    repeat (6) @(posedge iClk_12M);
    #1;
    check("abort_pre_macen", oMacEn, 1);
    check("abort_pre_tapidx", oTapIdx, 3);
    check("abort_pre_endelay", oEnDelay, 1);
    iEnable = 1'b0;
    @(posedge iClk_12M); #1;
    check("abort_macen", oMacEn, 0);
    check("abort_endelay", oEnDelay, 0);
    check("abort_tapidx", oTapIdx, 0);
    repeat (29) @(posedge iClk_12M);
    #1;
    check("disabled_strobe", oEnSample_600k, 0);
    check("disabled_endelay", oEnDelay, 0);
`ifdef FIR_ZERO_FLUSH_EN
    clearModel();
`endif
    iEnable = 1'b1;
    monEn   = 1;
    period(16'h0000);
    period(16'hABCD);
    for (int p = 3; p <= 41; p++) period(16'h0000);

    // Asynchronous reset in the middle of ACCUM with iEnable held high.
    iFirIn = 16'h3333;
    monEn  = 0;
    repeat (4) @(posedge iClk_12M);
    #1;
    check("rst_pre_macen", oMacEn, 1);
    iRst = 1'b1;
    #1;
    checkAllZero("async_rst");
    clearModel();
    @(posedge iClk_12M); #1;
    iRst  = 1'b0;
    monEn = 1;
    period(16'h4444);
    period(16'h0000);
    period(16'h0000);

    check("scoreboard_empty", q.size(), 0);
    monEn = 0;
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
